// File: rtl/wb_ram_slave.sv
// Pipelined Wishbone B4 slave RAM: fixed LATENCY-cycle in-order ack/err, at most
// MAX_OUTST requests in flight (stall when full), cyc drop aborts every pending response.
module wb_ram_slave #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_AW    = 10,
  parameter int LATENCY   = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADDR_W-1:0]   wb_adr_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic [DATA_W/8-1:0] wb_sel_i,
  input  logic                wb_lock_i,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_rty_o,
  output logic                wb_stall_o
);
  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic [DATA_W-1:0] mem_q [2**MEM_AW];

  logic [MEM_AW-1:0]  idx;
  logic               oor;
  logic               accept;
  logic               term;
  logic               stall;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] err_q, err_d;
  logic [DATA_W-1:0]  dat_q [LATENCY];
  logic [DATA_W-1:0]  dat_d [LATENCY];
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               unused_ok;

  assign unused_ok = ^{wb_lock_i, wb_adr_i[1:0]};

  assign idx    = wb_adr_i[MEM_AW+1:2];
  assign oor    = |wb_adr_i[ADDR_W-1:MEM_AW+2];
  assign stall  = (cnt_q == CNT_W'(MAX_OUTST));
  assign accept = wb_cyc_i & wb_stb_i & ~stall;
  // A termination is only issued while the cycle is still open; a cyc drop aborts it.
  assign term   = wb_cyc_i & vld_q[LATENCY-1];

  always_comb begin
    vld_d    = '0;
    err_d    = '0;
    vld_d[0] = accept;
    err_d[0] = oor;
    dat_d[0] = (!wb_we_i && !oor) ? mem_q[idx] : '0;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      err_d[i] = err_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
    if (!wb_cyc_i) begin
      vld_d = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!wb_cyc_i) begin
      cnt_d = '0;
    end else if (accept && !term) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!accept && term) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Payload only moves with a valid token, so the output data holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      err_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < LATENCY; i++) begin
        if (vld_d[i]) begin
          err_q[i] <= err_d[i];
          dat_q[i] <= dat_d[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && wb_we_i && !oor) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (wb_sel_i[b]) begin
          mem_q[idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
      end
    end
  end

  assign wb_ack_o   = term & ~err_q[LATENCY-1];
  assign wb_err_o   = term &  err_q[LATENCY-1];
  assign wb_rty_o   = 1'b0;
  assign wb_stall_o = stall;
  assign wb_dat_o   = dat_q[LATENCY-1];

endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: three instances with different LATENCY/MAX_OUTST share one
// request stream; a per-instance queue/array model predicts every termination and stall.
module tb_wb_ram_slave;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc_i, stb_i, we_i, lock_i;
  logic [31:0] adr_i, dat_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_o [3];
  logic        ack_o [3];
  logic        err_o [3];
  logic        rty_o [3];
  logic        stall_o [3];

  always #5 clk = ~clk;

  wb_ram_slave #(.LATENCY(2), .MAX_OUTST(4)) u_a (
    .clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc_i), .wb_stb_i(stb_i), .wb_we_i(we_i),
    .wb_adr_i(adr_i), .wb_dat_i(dat_i), .wb_sel_i(sel_i), .wb_lock_i(lock_i),
    .wb_dat_o(dat_o[0]), .wb_ack_o(ack_o[0]), .wb_err_o(err_o[0]), .wb_rty_o(rty_o[0]),
    .wb_stall_o(stall_o[0]));
  wb_ram_slave #(.LATENCY(4), .MAX_OUTST(2)) u_b (
    .clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc_i), .wb_stb_i(stb_i), .wb_we_i(we_i),
    .wb_adr_i(adr_i), .wb_dat_i(dat_i), .wb_sel_i(sel_i), .wb_lock_i(lock_i),
    .wb_dat_o(dat_o[1]), .wb_ack_o(ack_o[1]), .wb_err_o(err_o[1]), .wb_rty_o(rty_o[1]),
    .wb_stall_o(stall_o[1]));
  wb_ram_slave #(.LATENCY(5), .MAX_OUTST(3)) u_c (
    .clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc_i), .wb_stb_i(stb_i), .wb_we_i(we_i),
    .wb_adr_i(adr_i), .wb_dat_i(dat_i), .wb_sel_i(sel_i), .wb_lock_i(lock_i),
    .wb_dat_o(dat_o[2]), .wb_ack_o(ack_o[2]), .wb_err_o(err_o[2]), .wb_rty_o(rty_o[2]),
    .wb_stall_o(stall_o[2]));

  int lat [3] = '{2, 4, 5};
  int mx  [3] = '{4, 2, 3};

  // Reference model: word memory plus an in-order list of pending responses with due cycles.
  logic [31:0] mm     [3][1024];
  int          pd_due [3][16];
  bit          pd_err [3][16];
  bit          pd_rd  [3][16];
  logic [31:0] pd_dat [3][16];
  int          hd [3];
  int          nq [3];
  int          cyc_n;

  logic [31:0] last_rd   [3];
  bit          obs_stall [3];
  int          n_ack [3];
  int          n_err [3];

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] w0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One bus cycle: drive, check outputs mid-cycle, then advance the model on the edge.
  task automatic step(input bit c, input bit s, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] sl);
    bit front [3];
    cyc_i = c; stb_i = s; we_i = w; adr_i = a; dat_i = d; sel_i = sl;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      front[k] = (nq[k] > 0) && (pd_due[k][hd[k]] == cyc_n);
      chk($sformatf("ack%0d", k), 32'(ack_o[k]), 32'(c & front[k] & ~pd_err[k][hd[k]]));
      chk($sformatf("err%0d", k), 32'(err_o[k]), 32'(c & front[k] & pd_err[k][hd[k]]));
      chk($sformatf("stall%0d", k), 32'(stall_o[k]), 32'(nq[k] == mx[k]));
      if (c && front[k] && !pd_err[k][hd[k]] && pd_rd[k][hd[k]])
        chk($sformatf("rdat%0d", k), dat_o[k], pd_dat[k][hd[k]]);
      if (ack_o[k]) n_ack[k]++;
      if (err_o[k]) n_err[k]++;
      if (ack_o[k] && c && front[k] && pd_rd[k][hd[k]]) last_rd[k] = dat_o[k];
      obs_stall[k] = stall_o[k];
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      bit st;
      st = (nq[k] == mx[k]);
      if (!c) begin
        nq[k] = 0;
      end else begin
        if (front[k]) begin
          hd[k] = (hd[k] + 1) % 16;
          nq[k]--;
        end
        if (s && !st) begin
          int t;
          int ix;
          bit oor;
          t   = (hd[k] + nq[k]) % 16;
          oor = (a[31:12] != 20'h0);
          ix  = int'(a[11:2]);
          pd_due[k][t] = cyc_n + lat[k];
          pd_err[k][t] = oor;
          pd_rd[k][t]  = !w;
          pd_dat[k][t] = (!w && !oor) ? mm[k][ix] : 32'h0;
          if (w && !oor)
            for (int b = 0; b < 4; b++)
              if (sl[b]) mm[k][ix][8*b +: 8] = d[8*b +: 8];
          nq[k]++;
        end
      end
    end
    cyc_n++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Spaced request: every instance accepts it whatever its latency/depth.
  task automatic req(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
    step(1'b1, 1'b1, w, a, d, sl);
    idle(2);
  endtask

  initial begin
    bit          rc, rs, rw;
    logic [31:0] ra;
    int          a0 [3];
    int          e0 [3];

    rst_n = 1'b0;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; lock_i = 1'b0;
    adr_i = '0; dat_i = '0; sel_i = '0;
    cyc_n = 0;
    for (int k = 0; k < 3; k++) begin
      hd[k] = 0; nq[k] = 0; n_ack[k] = 0; n_err[k] = 0; last_rd[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ack%0d", k), 32'(ack_o[k]), 32'h0);
      chk($sformatf("rst_err%0d", k), 32'(err_o[k]), 32'h0);
      chk($sformatf("rst_stall%0d", k), 32'(stall_o[k]), 32'h0);
      chk($sformatf("rst_dat%0d", k), dat_o[k], 32'h0);
      chk($sformatf("rty%0d", k), 32'(rty_o[k]), 32'h0);
    end
    rst_n = 1'b1;

    w0 = $urandom;
    req(1'b1, 32'h0, w0, 4'hF);
    for (int i = 1; i < 32; i++) req(1'b1, 32'(i * 4), $urandom, 4'hF);

    req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    req(1'b0, 32'h10, 32'h0, 4'h0);
    idle(6);
    for (int k = 0; k < 3; k++) chk($sformatf("rd_deadbeef%0d", k), last_rd[k], 32'hDEADBEEF);

    req(1'b1, 32'h20, 32'h11223344, 4'hF);
    req(1'b1, 32'h20, 32'hAABBCCDD, 4'h5);
    req(1'b0, 32'h20, 32'h0, 4'h0);
    idle(6);
    for (int k = 0; k < 3; k++) chk($sformatf("byte_lane%0d", k), last_rd[k], 32'h11BB33DD);

    step(1'b1, 1'b1, 1'b1, 32'h40, 32'h5, 4'hF);
    step(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    idle(6);
    for (int k = 0; k < 3; k++) chk($sformatf("raw%0d", k), last_rd[k], 32'h5);

    for (int k = 0; k < 3; k++) begin e0[k] = n_err[k]; a0[k] = n_ack[k]; end
    req(1'b0, 32'h1000, 32'h0, 4'h0);
    req(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
    idle(6);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("oor_err%0d", k), 32'(n_err[k] - e0[k]), 32'd2);
      chk($sformatf("oor_noack%0d", k), 32'(n_ack[k] - a0[k]), 32'd0);
    end
    req(1'b0, 32'h0, 32'h0, 4'h0);
    idle(6);
    for (int k = 0; k < 3; k++) chk($sformatf("oor_word0_%0d", k), last_rd[k], w0);

    // Four back-to-back reads: the depth-2 instance stalls right after its 2nd accept.
    step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    step(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    step(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    chk("stall_b_after2", 32'(obs_stall[1]), 32'h1);
    chk("stall_a_never", 32'(obs_stall[0]), 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(8);

    for (int k = 0; k < 3; k++) a0[k] = n_ack[k];
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'(i * 4), 32'h0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(8);
    chk("abort_noack_c", 32'(n_ack[2] - a0[2]), 32'd0);
    req(1'b0, 32'h10, 32'h0, 4'h0);
    idle(6);
    chk("after_abort_ack_c", 32'(n_ack[2] - a0[2]), 32'd1);
    chk("after_abort_dat_c", last_rd[2], 32'hDEADBEEF);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'(i * 4), 32'h0, 4'h0);
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mid_rst_ack%0d", k), 32'(ack_o[k]), 32'h0);
      chk($sformatf("mid_rst_err%0d", k), 32'(err_o[k]), 32'h0);
      chk($sformatf("mid_rst_stall%0d", k), 32'(stall_o[k]), 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc_n++;
    for (int k = 0; k < 3; k++) nq[k] = 0;
    req(1'b0, 32'h40, 32'h0, 4'h0);
    idle(6);
    for (int k = 0; k < 3; k++) chk($sformatf("mem_kept%0d", k), last_rd[k], 32'h5);

    for (int i = 0; i < 1500; i++) begin
      rc = ($urandom_range(99) >= 3);
      rs = ($urandom_range(99) < 60);
      rw = 1'($urandom_range(1));
      if ($urandom_range(19) == 0) begin
        ra = $urandom;
        ra[12] = 1'b1;
      end else begin
        ra = 32'($urandom_range(31) * 4 + $urandom_range(3));
      end
      step(rc, rs, rw, ra, $urandom, 4'($urandom_range(15)));
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
